// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the core and the data memory port.
// Decodes the IR, checks alignment, shapes store data/masks and extends load results.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned TO_WIDTH = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] rdata_out_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wrbits_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StFault} state_e;

  localparam logic [TO_WIDTH-1:0] CntMax = TO_WIDTH'(TIMEOUT - 1);

  state_e              state_q;
  logic [TO_WIDTH-1:0] cnt_q;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;
  logic                we_q;
  logic [31:0]         addr_q, wrbits_q, wdata_q, rdata_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_store, is_load, f3_ok, misaligned, dec_ok;
  logic [31:0] wrmask, wrep, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic unused_ir;
  assign unused_ir = ^{ir_i[31:15], ir_i[11:7]};

  // Decode works on the live inputs so a fault is known at the start edge.
  always_comb begin
    opcode     = ir_i[6:0];
    funct3     = ir_i[14:12];
    is_store   = (opcode == 7'b0100011);
    is_load    = (opcode == 7'b0000011);
    f3_ok      = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                          : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((funct3[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    dec_ok     = (is_store || is_load) && f3_ok && !misaligned;
    case (funct3[1:0])
      2'b00: begin
        wrmask = 32'h0000_00FF << {addr_i[1:0], 3'b000};
        wrep   = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wrmask = 32'h0000_FFFF << {addr_i[1], 4'b0000};
        wrep   = {2{wdata_i[15:0]}};
      end
      default: begin
        wrmask = 32'hFFFF_FFFF;
        wrep   = wdata_i;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'(mem_rdata_i >> {off_q, 3'b000});
    ld_half = 16'(mem_rdata_i >> {off_q[1], 4'b0000});
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      f3_q     <= '0;
      off_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wrbits_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            f3_q  <= funct3;
            off_q <= addr_i[1:0];
            cnt_q <= '0;
            if (dec_ok) begin
              state_q  <= StAccess;
              we_q     <= is_store;
              addr_q   <= {addr_i[31:2], 2'b00};
              wrbits_q <= is_store ? wrmask : 32'h0;
              wdata_q  <= wrep;
            end else begin
              state_q <= StFault;
            end
          end
        end
        StAccess: begin
          if (mem_ack_i) begin
            state_q <= StDone;
            if (!we_q) rdata_q <= ld_val;
          end else if (cnt_q == CntMax) begin
            state_q <= StFault;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        StFault: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone) || (state_q == StFault);
  assign fault_o      = (state_q == StFault);
  assign mem_req_o    = (state_q == StAccess);
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wrbits_o = wrbits_q;
  assign mem_wdata_o  = wdata_q;
  assign rdata_out_o  = rdata_q;

endmodule
